// File: rtl/regfile_dump_controller.sv
// Register-file dump sequencer: walks every register through read port 1 and
// streams each word LS byte first over a valid/ready byte interface.
module regfile_dump_controller #(
  parameter int registers_width = 32,
  parameter int memory_depth    = 32,
  parameter int READ_LATENCY    = 1,
  localparam int AW = (memory_depth > 1) ? $clog2(memory_depth) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              pipe_read_reg,
  output logic [AW-1:0]              rf_read_reg,
  input  logic [registers_width-1:0] rf_read_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       pipe_stall,
  output logic                       done
);

  localparam int NB = registers_width / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(memory_depth - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t                     state, state_nx;
  logic [AW-1:0]              addr, addr_nx;
  logic [BW-1:0]              byte_idx, byte_idx_nx;
  logic [LW-1:0]              lat_cnt, lat_cnt_nx;
  logic [registers_width-1:0] word, word_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      byte_idx <= '0;
      lat_cnt  <= '0;
      word     <= '0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      byte_idx <= byte_idx_nx;
      lat_cnt  <= lat_cnt_nx;
      word     <= word_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    byte_idx_nx = byte_idx;
    lat_cnt_nx  = lat_cnt;
    word_nx     = word;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = WAIT;
          addr_nx    = '0;
          lat_cnt_nx = '0;
        end
      end
      WAIT: begin
        if (lat_cnt == LAST_LAT) state_nx = LOAD;
        else                     lat_cnt_nx = lat_cnt + 1'b1;
      end
      LOAD: begin
        word_nx     = rf_read_data;
        byte_idx_nx = '0;
        state_nx    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_idx != LAST_BYTE) begin
            byte_idx_nx = byte_idx + 1'b1;
          end else if (addr != LAST_ADDR) begin
            addr_nx    = addr + 1'b1;
            lat_cnt_nx = '0;
            state_nx   = WAIT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        addr_nx  = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode from the state register so an async reset clears them at once.
  assign busy        = (state != IDLE);
  assign pipe_stall  = busy;
  assign done        = (state == DONE);
  assign tx_valid    = (state == SEND);
  assign tx_data     = tx_valid ? word[{byte_idx, 3'b000} +: 8] : '0;
  assign rf_read_reg = busy ? addr : pipe_read_reg;

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Bench for regfile_dump_controller: register-file model plus expected byte
// streams derived directly from the stored register contents.
module tb_regfile_dump_controller;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NB = W / 8;
  localparam int DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, tx_ready, busy, pipe_stall, done, tx_valid;
  logic [4:0]   pipe_read_reg, rf_read_reg;
  logic [W-1:0] rf_read_data;
  logic [7:0]   tx_data;
  logic [W-1:0] regs [D];

  logic         b_start, b_tx_ready, b_busy, b_pipe_stall, b_done, b_tx_valid;
  logic [1:0]   b_pipe_read_reg, b_rf_read_reg, b_pipe;
  logic [W-1:0] b_rf_read_data;
  logic [7:0]   b_tx_data;
  logic [W-1:0] regs_b [DB];

  regfile_dump_controller #(.registers_width(W), .memory_depth(D), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .pipe_read_reg(pipe_read_reg),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .pipe_stall(pipe_stall),
    .done(done));

  regfile_dump_controller #(.registers_width(W), .memory_depth(DB), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .pipe_read_reg(b_pipe_read_reg),
    .rf_read_reg(b_rf_read_reg), .rf_read_data(b_rf_read_data), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .busy(b_busy), .pipe_stall(b_pipe_stall),
    .done(b_done));

  // Register-file models: one- and two-cycle read latency.
  always @(posedge clk) rf_read_data <= regs[rf_read_reg];
  always @(posedge clk) begin
    b_pipe         <= b_rf_read_reg;
    b_rf_read_data <= regs_b[b_pipe];
  end

  int checks = 0, passed = 0;
  logic [7:0] got[$];
  int seen_addr[$];
  int stall_err, follow_err, done_cnt, busy_cyc, first_busy, first_valid, post_busy;
  bit got_done;

  function automatic int stream_errs();
    int e = (got.size() == D * NB) ? 0 : 1;
    for (int i = 0; i < D; i++)
      for (int b = 0; b < NB; b++)
        if (i * NB + b < got.size())
          if (got[i * NB + b] !== regs[i][8 * b +: 8]) e++;
    return e;
  endfunction

  function automatic int addr_errs();
    int e = (seen_addr.size() == D) ? 0 : 1;
    for (int i = 0; i < seen_addr.size(); i++) if (seen_addr[i] != i) e++;
    return e;
  endfunction

  // mode 0: ready always high, 1: toggles every 3 cycles, 2: random
  task automatic run_dump(input int mode, input int restart_at);
    logic       pv;
    logic [7:0] pd;
    got.delete(); seen_addr.delete();
    stall_err = 0; follow_err = 0; done_cnt = 0; busy_cyc = 0;
    first_busy = -1; first_valid = -1; got_done = 0;
    pv = 1'b0; pd = '0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = (cyc == restart_at);
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc / 3) % 2) == 0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        if (first_busy < 0) first_busy = cyc;
        if (seen_addr.size() == 0 || seen_addr[$] != int'(rf_read_reg))
          seen_addr.push_back(int'(rf_read_reg));
      end
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (pv && (!tx_valid || tx_data !== pd)) stall_err++;
      if (tx_valid && rf_read_reg !== 5'(got.size() / NB)) follow_err++;
      if (busy !== pipe_stall) follow_err++;
      if (!busy && rf_read_reg !== pipe_read_reg) follow_err++;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      pv = tx_valid && !tx_ready;
      pd = tx_data;
      if (done) begin
        done_cnt++;
        got_done = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic settle();
    post_busy = 0;
    repeat (8) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) post_busy++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pipe_read_reg = 5'd9;
    @(negedge clk);
    checks++; if ({busy, tx_valid, done, pipe_stall} !== 4'b0) $display("FAIL reset_ctl: got %b expected 0000", {busy, tx_valid, done, pipe_stall}); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
    checks++; if (rf_read_reg !== 5'd9) $display("FAIL reset_mux: got %0d expected 9", rf_read_reg); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < D; i++) regs[i] = 32'h0000_0100 * i + i;
    run_dump(0, -1);
    checks++; if (!got_done) $display("FAIL full_timeout: got no done expected done"); else passed++;
    checks++; if (stream_errs() != 0) $display("FAIL full_stream: got %0d errors (%0d bytes) expected 0 (128 bytes)", stream_errs(), got.size()); else passed++;
    checks++; if ({got[12], got[13], got[14], got[15]} !== 32'h0303_0000) $display("FAIL full_reg3: got %h expected 03030000", {got[12], got[13], got[14], got[15]}); else passed++;
    checks++; if (busy_cyc != D * (1 + 1 + NB) + 1) $display("FAIL full_busy_cycles: got %0d expected %0d", busy_cyc, D * (2 + NB) + 1); else passed++;
    checks++; if (first_valid - first_busy != 2) $display("FAIL full_latency: got %0d expected 2", first_valid - first_busy); else passed++;
    settle();
    checks++; if (done_cnt != 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt); else passed++;
    checks++; if (post_busy != 0) $display("FAIL full_busy_after: got %0d expected 0", post_busy); else passed++;
  endtask

  task automatic test_backpressure();
    run_dump(1, -1);
    checks++; if (stream_errs() != 0) $display("FAIL bp_stream: got %0d errors expected 0", stream_errs()); else passed++;
    checks++; if (stall_err != 0) $display("FAIL bp_stable: got %0d changes expected 0", stall_err); else passed++;
    settle();
    checks++; if (done_cnt != 1) $display("FAIL bp_done_count: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < D; i++) regs[i] = $urandom;
    run_dump(2, -1);
    checks++; if (stream_errs() != 0) $display("FAIL rand_stream: got %0d errors expected 0", stream_errs()); else passed++;
    checks++; if (stall_err != 0) $display("FAIL rand_stable: got %0d changes expected 0", stall_err); else passed++;
    settle();
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < D; i++) regs[i] = $urandom;
    run_dump(0, 40 + int'($urandom_range(0, 50)));
    checks++; if (addr_errs() != 0) $display("FAIL restart_addr_seq: got %0d errors expected 0", addr_errs()); else passed++;
    checks++; if (stream_errs() != 0) $display("FAIL restart_stream: got %0d errors expected 0", stream_errs()); else passed++;
    settle();
    checks++; if (done_cnt != 1) $display("FAIL restart_done_count: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_done_restart();
    run_dump(0, -1);
    start = 1'b1;                 // seen on the edge leaving DONE
    @(posedge clk); #1;           // still high in the first IDLE cycle
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL done_start_ignored: got busy=%b expected 0", busy); else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rf_read_reg !== 5'd0) $display("FAIL idle_start_taken: got busy=%b addr=%0d expected busy=1 addr=0", busy, rf_read_reg); else passed++;
    do_reset();
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    for (int i = 0; i < D; i++) regs[i] = $urandom;
    @(posedge clk); #1;
    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      if (tx_valid && rf_read_reg == 5'd10) hit = 1;
    end
    checks++; if (!hit) $display("FAIL rst_reach_reg10: got timeout expected SEND on reg 10"); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if ({tx_valid, busy, pipe_stall} !== 3'b000) $display("FAIL rst_async: got %b expected 000", {tx_valid, busy, pipe_stall}); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    run_dump(0, -1);
    checks++; if (seen_addr.size() == 0 || seen_addr[0] != 0) $display("FAIL rst_restart_addr: got %0d expected 0", (seen_addr.size() != 0) ? seen_addr[0] : -1); else passed++;
    checks++; if (stream_errs() != 0) $display("FAIL rst_restart_stream: got %0d errors expected 0", stream_errs()); else passed++;
    settle();
  endtask

  task automatic test_read_mux();
    pipe_read_reg = 5'd17;
    @(negedge clk);
    checks++; if (rf_read_reg !== 5'd17) $display("FAIL mux_idle: got %0d expected 17", rf_read_reg); else passed++;
    run_dump(2, -1);
    checks++; if (follow_err != 0) $display("FAIL mux_follow: got %0d errors expected 0", follow_err); else passed++;
    settle();
    checks++; if (rf_read_reg !== 5'd17) $display("FAIL mux_after: got %0d expected 17", rf_read_reg); else passed++;
  endtask

  task automatic test_latency2();
    logic [7:0] gb[$];
    int fb = -1, fv = -1, dc = 0, errs;
    regs_b[0] = 32'hDEADBEEF;
    for (int i = 1; i < DB; i++) regs_b[i] = $urandom;
    @(posedge clk); #1;
    b_start = 1'b1; b_tx_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        b_start = 1'b0;
      end
      @(negedge clk);
      if (b_busy && fb < 0) fb = cyc;
      if (b_tx_valid && fv < 0) fv = cyc;
      if (b_tx_valid && b_tx_ready) gb.push_back(b_tx_data);
      if (b_done) dc++;
      if (dc != 0 && !b_busy) break;
    end
    errs = (gb.size() == DB * NB) ? 0 : 1;
    for (int i = 0; i < DB; i++)
      for (int b = 0; b < NB; b++)
        if (i * NB + b < gb.size() && gb[i * NB + b] !== regs_b[i][8 * b +: 8]) errs++;
    checks++; if ({gb[0], gb[1], gb[2], gb[3]} !== 32'hEFBEADDE) $display("FAIL lat2_first_bytes: got %h expected efbeadde", {gb[0], gb[1], gb[2], gb[3]}); else passed++;
    checks++; if (errs != 0) $display("FAIL lat2_stream: got %0d errors expected 0", errs); else passed++;
    checks++; if (fv - fb != 3) $display("FAIL lat2_first_valid: got %0d expected 3", fv - fb); else passed++;
    checks++; if (dc != 1) $display("FAIL lat2_done_count: got %0d expected 1", dc); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; pipe_read_reg = '0;
    b_start = 1'b0; b_tx_ready = 1'b0; b_pipe_read_reg = 2'd1;
    for (int i = 0; i < D; i++) regs[i] = '0;
    for (int i = 0; i < DB; i++) regs_b[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_random();
    test_restart_ignored();
    test_done_restart();
    test_reset_mid_dump();
    test_read_mux();
    test_latency2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
